return_addr_stack: RTL and testbench

//   Hardware return-address stack for the RAT CPU. Pairs with the program counter.
//   - On CALL / interrupt entry: captures a return address presented by the control

---
 rtl/return_addr_stack.sv | 97 +++++++++
 tb/tb_return_addr_stack.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/return_addr_stack.sv
// Return-address stack for the RAT CPU: strict LIFO of PC return addresses with
// full/empty status and sticky overflow/underflow flags.
module return_addr_stack #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       PUSH,
  input  logic [ADDR_W-1:0]          PUSH_ADDR,
  input  logic                       POP,
  input  logic                       CLR_ERR,
  output logic [ADDR_W-1:0]          RET_ADDR,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, udf_q;
  logic              ovf_set, udf_set;
  logic              wr_en;
  logic [PW-1:0]     wr_idx;
  logic [PW-1:0]     top_idx;
  logic              empty_c, full_c;

  assign empty_c = (count_q == CW'(0));
  assign full_c  = (count_q == CW'(DEPTH));
  assign top_idx = PW'(count_q - CW'(1));

  // Next-state decode for each PUSH/POP combination
  always_comb begin
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    case ({PUSH, POP})
      2'b10: begin
        if (full_c) begin
          ovf_set = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = count_q[PW-1:0];
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty_c) udf_set = 1'b1;
        else         count_d = count_q - CW'(1);
      end
      2'b11: begin
        // Simultaneous push+pop replaces the top; on empty the pop underflows but the push lands.
        wr_en = 1'b1;
        if (empty_c) begin
          udf_set = 1'b1;
          wr_idx  = '0;
          count_d = CW'(1);
        end else begin
          wr_idx  = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_set | (ovf_q & ~CLR_ERR);
      udf_q   <= udf_set | (udf_q & ~CLR_ERR);
    end
  end

  // Entry storage is intentionally not reset; reset still suppresses a concurrent write.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) mem[wr_idx] <= PUSH_ADDR;
  end

  assign RET_ADDR  = empty_c ? '0 : mem[top_idx];
  assign COUNT     = count_q;
  assign EMPTY     = empty_c;
  assign FULL      = full_c;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack: directed scenarios plus random
// traffic against a queue-based LIFO reference model.
module tb_return_addr_stack;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 32;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              PUSH = 1'b0;
  logic [ADDR_W-1:0] PUSH_ADDR = '0;
  logic              POP = 1'b0;
  logic              CLR_ERR = 1'b0;
  logic [ADDR_W-1:0] RET_ADDR;
  logic [$clog2(DEPTH):0] COUNT;
  logic              EMPTY, FULL, OVERFLOW, UNDERFLOW;

  return_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .PUSH(PUSH), .PUSH_ADDR(PUSH_ADDR), .POP(POP),
    .CLR_ERR(CLR_ERR), .RET_ADDR(RET_ADDR), .COUNT(COUNT), .EMPTY(EMPTY),
    .FULL(FULL), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain LIFO queue plus two sticky bits
  logic [ADDR_W-1:0] model_q[$];
  bit model_ovf = 1'b0;
  bit model_udf = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_top();
    if (model_q.size() == 0) return 0;
    return int'(model_q[model_q.size()-1]);
  endfunction

  task automatic model_update(input bit rst, input bit push, input bit pop,
                              input bit clr, input logic [ADDR_W-1:0] addr);
    bit no = 1'b0;
    bit nu = 1'b0;
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_udf = 1'b0;
    end else begin
      if (push && pop) begin
        if (model_q.size() == 0) begin
          nu = 1'b1;
          model_q.push_back(addr);
        end else begin
          model_q[model_q.size()-1] = addr;
        end
      end else if (push) begin
        if (model_q.size() == DEPTH) no = 1'b1;
        else model_q.push_back(addr);
      end else if (pop) begin
        if (model_q.size() == 0) nu = 1'b1;
        else void'(model_q.pop_back());
      end
      model_ovf = no | (model_ovf & !clr);
      model_udf = nu | (model_udf & !clr);
    end
  endtask

  task automatic check_all();
    chk("ret_addr",  int'(RET_ADDR),  model_top());
    chk("count",     int'(COUNT),     model_q.size());
    chk("empty",     int'(EMPTY),     int'(model_q.size() == 0));
    chk("full",      int'(FULL),      int'(model_q.size() == DEPTH));
    chk("overflow",  int'(OVERFLOW),  int'(model_ovf));
    chk("underflow", int'(UNDERFLOW), int'(model_udf));
  endtask

  // Apply one cycle of inputs, clock it, update the model, then compare
  task automatic step(input bit rst, input bit push, input bit pop, input bit clr,
                      input logic [ADDR_W-1:0] addr);
    RST = rst; PUSH = push; POP = pop; CLR_ERR = clr; PUSH_ADDR = addr;
    @(posedge CLK);
    model_update(rst, push, pop, clr, addr);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic push_v(input logic [ADDR_W-1:0] a);
    step(1'b0, 1'b1, 1'b0, 1'b0, a);
  endtask

  task automatic pop_v();
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  logic [ADDR_W-1:0] exp_pops[3];
  int bias;

  initial begin
    #1;
    // Reset then idle
    do_reset();
    repeat (3) idle();
    chk("rst_count", int'(COUNT), 0);
    chk("rst_empty", int'(EMPTY), 1);
    chk("rst_ret",   int'(RET_ADDR), 0);
    chk("rst_flags", int'({OVERFLOW, UNDERFLOW}), 0);

    // LIFO order with zero-latency pop read
    push_v(10'h010); push_v(10'h020); push_v(10'h3FF);
    exp_pops[0] = 10'h3FF; exp_pops[1] = 10'h020; exp_pops[2] = 10'h010;
    for (int i = 0; i < 3; i++) begin
      POP = 1'b1; PUSH = 1'b0;
      #1;
      chk("pop_ret", int'(RET_ADDR), int'(exp_pops[i]));
      pop_v();
    end
    chk("pop_empty", int'(EMPTY), 1);
    chk("pop_ret0",  int'(RET_ADDR), 0);

    // Fill, overflow, clear
    for (int i = 1; i <= 32; i++) push_v(ADDR_W'(i));
    chk("fill_full", int'(FULL), 1);
    push_v(10'h155);
    chk("ovf_flag",  int'(OVERFLOW), 1);
    chk("ovf_count", int'(COUNT), 32);
    chk("ovf_ret",   int'(RET_ADDR), 32);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("ovf_clr",   int'(OVERFLOW), 0);

    // Replace top while full
    step(1'b0, 1'b1, 1'b1, 1'b0, 10'h111);
    chk("rep_full_ret", int'(RET_ADDR), 'h111);
    chk("rep_full_cnt", int'(COUNT), 32);
    chk("rep_full_ovf", int'(OVERFLOW), 0);

    // Underflow, then push+pop on empty
    do_reset();
    pop_v();
    chk("udf_flag",  int'(UNDERFLOW), 1);
    chk("udf_count", int'(COUNT), 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 10'h0AA);
    chk("pp_empty_cnt", int'(COUNT), 1);
    chk("pp_empty_ret", int'(RET_ADDR), 'h0AA);
    chk("pp_empty_udf", int'(UNDERFLOW), 1);

    // Replace top at COUNT=2
    do_reset();
    push_v(10'h010); push_v(10'h020);
    step(1'b0, 1'b1, 1'b1, 1'b0, 10'h111);
    chk("rep_cnt", int'(COUNT), 2);
    chk("rep_ret", int'(RET_ADDR), 'h111);
    pop_v();
    chk("rep_below", int'(RET_ADDR), 'h010);

    // Reset beats a concurrent push
    push_v(10'h001); push_v(10'h002); push_v(10'h003);
    step(1'b1, 1'b1, 1'b0, 1'b0, 10'h2AB);
    chk("rstp_count", int'(COUNT), 0);
    chk("rstp_empty", int'(EMPTY), 1);
    chk("rstp_ret",   int'(RET_ADDR), 0);

    // Random traffic with phases biased toward filling and draining
    bias = 50;
    for (int c = 0; c < 10000; c++) begin
      bit r_rst, r_push, r_pop, r_clr;
      if (c % 200 == 0) bias = (($urandom_range(0, 2)) * 30) + 20;
      r_rst  = ($urandom_range(0, 499) == 0);
      r_push = ($urandom_range(0, 99) < bias);
      r_pop  = ($urandom_range(0, 99) < (100 - bias));
      r_clr  = ($urandom_range(0, 19) == 0);
      step(r_rst, r_push, r_pop, r_clr, ADDR_W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
